bpu_tournament: RTL and testbench
=================================

Name: bpu_tournament

Overview:
- Parametrised successor to the single-scheme local-history direction predictor in the 5-stage MIPS pipeline.
- Provides local, gshare or tournament direction prediction, selected by parameter.
- Timing: predicts at F, presents the prediction at D, resolves and updates at M.
- Carries per-branch prediction metadata D→E→M internally, so the datapath only supplies flush/stall and resolution signals; also reports mispredicts and keeps performance counters.

Parameters:
PC_IDX_BITS, 6, index width into BHT (2^N local-history entries), taken from pc[N+1:2]
LHIST_BITS, 4, local history length; local PHT has 2^N entries
GHIST_BITS, 6, GHR length and gshare PHT index width
CHOOSE_BITS, 6, chooser table index width, taken from pc[N+1:2]
MODE, 2, 0 = local only, 1 = gshare only, 2 = tournament

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pcF  in  32  fetch PC
stallD  in  1  hold F→D metadata register
flushD  in  1  clear F→D register (sync)
branchD  in  1  instruction in D is a conditional branch
flushE  in  1  clear D→E shadow (sync)
flushM  in  1  clear E→M shadow (sync)
branchM  in  1  instruction in M is a conditional branch
actual_takeM  in  1  resolved direction at M
pred_takeD  out  1  predicted taken, valid in D
mispredM  out  1  M-stage branch resolved opposite to its prediction
br_cnt  out  32  resolved branches since reset
mis_cnt  out  32  mispredictions since reset

Behaviour:
- Reset (async, immediate):
  - BHT entries = 0; GHR = 0.
  - All 2-bit counters (local PHT, global PHT, chooser) = 2'b01.
  - All pipeline metadata = 0; br_cnt = mis_cnt = 0; pred_takeD = 0; mispredM = 0.
- F stage (combinational):
  - lidx = pcF[PC_IDX_BITS+1:2]; lhist = BHT[lidx]; lpred = LPHT[lhist][1].
  - gidx = pcF[GHIST_BITS+1:2] ^ GHR; gpred = GPHT[gidx][1].
  - cidx = pcF[CHOOSE_BITS+1:2]; choice = CPHT[cidx][1] (1 selects global).
  - pred = MODE0: lpred; MODE1: gpred; MODE2: choice ? gpred : lpred.
- F→D register {pred, lidx, lhist, gidx, cidx, lpred, gpred}:
  - Loads when ~stallD.
  - flushD clears it and has priority over stall.
- pred_takeD = branchD & pred_regD.
- D→E shadow: loads every cycle with valid = branchD plus the metadata; flushE clears valid and metadata. Same rule for E→M with flushM.
- Update (rising edge, when validM & branchM):
  - BHT[lidxM] <= {lhistM[LHIST_BITS-2:0], actual_takeM}.
  - LPHT[lhistM] and GPHT[gidxM]: saturating ±1 (clamp at 00/11); both update in every MODE.
  - Chooser: MODE 2 only, and only when lpredM != gpredM. Increment if gpredM == actual, else decrement; saturating.
  - GHR <= {GHR[GHIST_BITS-2:0], actual_takeM}. GHR is committed, non-speculative history; gidx at F uses the current committed GHR.
  - br_cnt += 1. mis_cnt += 1 when predM != actual_takeM. Both saturate at 0xFFFF_FFFF.
- mispredM = validM & branchM & (predM != actual_takeM); combinational.
- Same-cycle update and F read of the same entry: F reads the pre-update value; no bypass.
- Table update is blocked when flushM is asserted in the cycle the branch would enter M.
- Reset mid-operation discards all in-flight metadata.
- Arrays may be flops; read is combinational.

Decomposition:
- Shared package: MODE encodings (MODE_LOCAL = 0, MODE_GSHARE = 1, MODE_TOUR = 2) and the counter reset constant CNT_WNT = 2'b01.
- One natural sub-module: sat_cnt2. It takes a 2-bit counter value and a taken bit and returns the saturated next value; instantiate it for the local PHT, global PHT and chooser paths.

Test Plan:
- Reset, then pcF = 0x0000_0040 with branchD = 1 → pred_takeD = 0; br_cnt = mis_cnt = 0; the same holds in every MODE.
- MODE 0, a single branch at 0x40 resolved taken 8 times, each resolution completing before the next fetch → predictions 1–5 not-taken, 6–8 taken; mis_cnt = 5, br_cnt = 8.
- Saturation: drive LPHT[1111] to 11 with 3 more takens, then one not-taken → next prediction still taken (counter = 10); a second not-taken → not-taken.
- Branch in E with flushM asserted → no BHT/PHT/GHR change, br_cnt unchanged, mispredM = 0.
- MODE 2, gpred correct and lpred wrong 2 times at cidx 0x10 → chooser goes 01→10→11; the next branch with that cidx selects gshare. With lpred == gpred, the chooser stays unchanged.
- Assert rst asynchronously while a mispredicted branch sits in M → mispredM and pred_takeD fall to 0 without waiting for a clock edge; counters read 0 afterwards.

Source files
------------

// File: rtl/bpu_tournament_pkg.sv
// Shared definitions for the tournament branch direction predictor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bpu_tournament_pkg;

    // Predictor scheme selection for the MODE parameter.
    localparam int MODE_LOCAL  = 0;
    localparam int MODE_GSHARE = 1;
    localparam int MODE_TOUR   = 2;

    // Reset value of every 2-bit counter: weakly not-taken
    // (for the chooser: weakly prefer local).
    localparam logic [1:0] CNT_WNT = 2'b01;

endpackage

// File: rtl/sat_cnt2.sv
// 2-bit saturating up/down counter next-value logic.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//   cntIn  : current counter value
//   taken  : 1 = count up, 0 = count down
//   cntOut : next counter value, clamped at 2'b00 and 2'b11
module sat_cnt2 (
    input  logic [1:0] cntIn,
    input  logic       taken,
    output logic [1:0] cntOut
);

    always_comb begin
        cntOut = cntIn;
        if (taken && (cntIn != 2'b11)) begin
            cntOut = cntIn + 2'd1;
        end else if (!taken && (cntIn != 2'b00)) begin
            cntOut = cntIn - 2'd1;
        end
    end

endmodule

// File: rtl/bpu_tournament.sv
// Local / gshare / tournament branch direction predictor for the 5-stage pipeline.
// Latency: lookup at F, prediction valid in D (1 cycle), tables trained at the M-stage edge.
// Backpressure: stallD holds the F->D metadata; flushD/E/M squash in-flight metadata.
//   clk, rst                 : clock, asynchronous active-high reset
//   pcF                      : fetch PC used for all table lookups
//   stallD, flushD           : hold / clear the F->D metadata register
//   branchD, flushE          : D-stage branch flag, clear of the D->E shadow
//   flushM, branchM          : clear of the E->M shadow, M-stage branch flag
//   actual_takeM             : resolved direction at M
//   pred_takeD               : predicted taken for the branch in D
//   mispredM                 : M-stage branch resolved against its prediction
//   br_cnt, mis_cnt          : saturating resolved-branch / mispredict counters
module bpu_tournament
    import bpu_tournament_pkg::*;
#(
    parameter int PC_IDX_BITS = 6,
    parameter int LHIST_BITS  = 4,
    parameter int GHIST_BITS  = 6,
    parameter int CHOOSE_BITS = 6,
    parameter int MODE        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchD,
    input  logic        flushE,
    input  logic        flushM,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        mispredM,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam int BHT_N  = 1 << PC_IDX_BITS;
    localparam int LPHT_N = 1 << LHIST_BITS;
    localparam int GPHT_N = 1 << GHIST_BITS;
    localparam int CPHT_N = 1 << CHOOSE_BITS;

    // Everything a branch needs at M to train the tables it was predicted from.
    typedef struct packed {
        logic                   pred;
        logic [PC_IDX_BITS-1:0] lidx;
        logic [LHIST_BITS-1:0]  lhist;
        logic [GHIST_BITS-1:0]  gidx;
        logic [CHOOSE_BITS-1:0] cidx;
        logic                   lpred;
        logic                   gpred;
    } meta_t;

    logic [LHIST_BITS-1:0] bht  [BHT_N];
    logic [1:0]            lpht [LPHT_N];
    logic [1:0]            gpht [GPHT_N];
    logic [1:0]            cpht [CPHT_N];
    logic [GHIST_BITS-1:0] ghr;

    meta_t metaF, metaD, metaE, metaM;
    logic  validE, validM;
    logic  choiceF;
    logic  doUpdate;
    logic  [1:0] lphtNext, gphtNext, cphtNext;

    // Only a slice of the PC indexes the tables; the rest is intentionally ignored.
    logic [31:0] unusedPcF;
    assign unusedPcF = pcF;

    // ---------------- F stage lookup ----------------
    assign metaF.lidx  = pcF[PC_IDX_BITS+1:2];
    assign metaF.lhist = bht[metaF.lidx];
    assign metaF.lpred = lpht[metaF.lhist][1];
    // gshare uses committed history only, so a resolving branch in M is not yet visible here.
    assign metaF.gidx  = pcF[GHIST_BITS+1:2] ^ ghr;
    assign metaF.gpred = gpht[metaF.gidx][1];
    assign metaF.cidx  = pcF[CHOOSE_BITS+1:2];
    assign choiceF     = cpht[metaF.cidx][1];

    generate
        if (MODE == MODE_LOCAL) begin : g_predLocal
            assign metaF.pred = metaF.lpred;
        end else if (MODE == MODE_GSHARE) begin : g_predGshare
            assign metaF.pred = metaF.gpred;
        end else begin : g_predTour
            assign metaF.pred = choiceF ? metaF.gpred : metaF.lpred;
        end
    endgenerate

    // ---------------- metadata pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            metaD <= '0;
        end else if (flushD) begin
            metaD <= '0;
        end else if (!stallD) begin
            metaD <= metaF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validE <= 1'b0;
            metaE  <= '0;
        end else if (flushE) begin
            validE <= 1'b0;
            metaE  <= '0;
        end else begin
            validE <= branchD;
            metaE  <= metaD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validM <= 1'b0;
            metaM  <= '0;
        end else if (flushM) begin
            validM <= 1'b0;
            metaM  <= '0;
        end else begin
            validM <= validE;
            metaM  <= metaE;
        end
    end

    assign pred_takeD = branchD & metaD.pred;
    assign doUpdate   = validM & branchM;
    assign mispredM   = doUpdate & (metaM.pred != actual_takeM);

    // ---------------- training ----------------
    sat_cnt2 u_lphtCnt (
        .cntIn  (lpht[metaM.lhist]),
        .taken  (actual_takeM),
        .cntOut (lphtNext)
    );

    sat_cnt2 u_gphtCnt (
        .cntIn  (gpht[metaM.gidx]),
        .taken  (actual_takeM),
        .cntOut (gphtNext)
    );

    // Chooser moves toward whichever component was right.
    sat_cnt2 u_cphtCnt (
        .cntIn  (cpht[metaM.cidx]),
        .taken  (metaM.gpred == actual_takeM),
        .cntOut (cphtNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= '0;
            for (int i = 0; i < LPHT_N; i++) lpht[i] <= CNT_WNT;
            for (int i = 0; i < GPHT_N; i++) gpht[i] <= CNT_WNT;
            for (int i = 0; i < CPHT_N; i++) cpht[i] <= CNT_WNT;
            ghr <= '0;
        end else if (doUpdate) begin
            bht[metaM.lidx]   <= {metaM.lhist[LHIST_BITS-2:0], actual_takeM};
            // Both component tables train in every mode so switching MODE needs no warm-up logic.
            lpht[metaM.lhist] <= lphtNext;
            gpht[metaM.gidx]  <= gphtNext;
            // Chooser only learns when the components disagree; agreement carries no information.
            if ((MODE == MODE_TOUR) && (metaM.lpred != metaM.gpred)) begin
                cpht[metaM.cidx] <= cphtNext;
            end
            ghr <= {ghr[GHIST_BITS-2:0], actual_takeM};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else if (doUpdate) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (mispredM && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bpu_tournament.sv
// Directed-vector bench for bpu_tournament: one instance per MODE, shared stimulus.
// Latency: branch fetched at F, checked in D, resolved two cycles later in M.
// Backpressure: stall/flushD/flushE held low; flushM exercised once.
module tb_bpu_tournament;
    import bpu_tournament_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD, flushD, branchD, flushE, flushM, branchM, actual_takeM;
    logic        predTake [3];
    logic        mispred  [3];
    logic [31:0] brCnt    [3];
    logic [31:0] misCnt   [3];

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        bpu_tournament #(
            .PC_IDX_BITS (6),
            .LHIST_BITS  (4),
            .GHIST_BITS  (6),
            .CHOOSE_BITS (6),
            .MODE        (m)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .pcF          (pcF),
            .stallD       (stallD),
            .flushD       (flushD),
            .branchD      (branchD),
            .flushE       (flushE),
            .flushM       (flushM),
            .branchM      (branchM),
            .actual_takeM (actual_takeM),
            .pred_takeD   (predTake[m]),
            .mispredM     (mispred[m]),
            .br_cnt       (brCnt[m]),
            .mis_cnt      (misCnt[m])
        );
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One branch through F/D/E/M with nothing else in flight; resolution
    // completes before the following fetch. Checks instance d.
    task automatic runBranch(input logic [31:0] pc, input logic taken, input logic flushIt,
                             input int d, input logic expPred, input logic expMis,
                             input string tag);
        @(negedge clk);
        pcF = pc; branchD = 1'b0; branchM = 1'b0; flushM = 1'b0;
        @(negedge clk);
        branchD = 1'b1;
        #1 checkVal({tag, " pred"}, predTake[d], expPred);
        @(negedge clk);
        branchD = 1'b0; flushM = flushIt;
        @(negedge clk);
        flushM = 1'b0; branchM = 1'b1; actual_takeM = taken;
        #1 checkVal({tag, " mispred"}, mispred[d], expMis);
        @(negedge clk);
        branchM = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; branchD = 1'b0; branchM = 1'b0; flushM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pcF = '0; stallD = 1'b0; flushD = 1'b0; branchD = 1'b0;
        flushE = 1'b0; flushM = 1'b0; branchM = 1'b0; actual_takeM = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, all modes: fresh counters predict not-taken.
        pcF = 32'h0000_0040;
        @(negedge clk);
        branchD = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            checkVal($sformatf("reset predD m%0d", m), predTake[m], 1'b0);
            checkVal($sformatf("reset mispred m%0d", m), mispred[m], 1'b0);
            checkVal($sformatf("reset br_cnt m%0d", m), brCnt[m], 32'd0);
            checkVal($sformatf("reset mis_cnt m%0d", m), misCnt[m], 32'd0);
        end
        @(negedge clk);
        branchD = 1'b0;
        repeat (3) @(negedge clk);

        // MODE 0: eight takens at 0x40; history walks 0000->1111.
        for (int i = 0; i < 8; i++) begin
            runBranch(32'h40, 1'b1, 1'b0, 0, (i >= 5), (i < 5), $sformatf("m0 br%0d", i + 1));
        end
        checkVal("m0 br_cnt", brCnt[0], 32'd8);
        checkVal("m0 mis_cnt", misCnt[0], 32'd5);

        // Flushed at E->M: would mispredict and retrain, but must leave no trace.
        runBranch(32'h40, 1'b0, 1'b1, 0, 1'b1, 1'b0, "flushM");
        checkVal("flushM br_cnt", brCnt[0], 32'd8);

        // Three more takens at 0x40 (LPHT[1111] pinned at 11; history unchanged by the flush).
        for (int i = 0; i < 3; i++) runBranch(32'h40, 1'b1, 1'b0, 0, 1'b1, 1'b0, $sformatf("sat A%0d", i));
        // Bring two more branches' histories to 1111.
        for (int i = 0; i < 4; i++) runBranch(32'h44, 1'b1, 1'b0, 0, 1'b1, 1'b0, $sformatf("sat B%0d", i));
        for (int i = 0; i < 4; i++) runBranch(32'h48, 1'b1, 1'b0, 0, 1'b1, 1'b0, $sformatf("sat C%0d", i));
        // 11 -> 10: still taken; 10 -> 01: not taken.
        runBranch(32'h40, 1'b0, 1'b0, 0, 1'b1, 1'b1, "sat nt1");
        runBranch(32'h44, 1'b0, 1'b0, 0, 1'b1, 1'b1, "sat nt2");
        runBranch(32'h48, 1'b0, 1'b0, 0, 1'b0, 1'b0, "sat nt3");
        checkVal("sat br_cnt", brCnt[0], 32'd22);
        checkVal("sat mis_cnt", misCnt[0], 32'd7);

        // MODE 2 chooser at cidx 0x10.
        doReset();
        @(negedge clk);
        checkVal("m2 reset br_cnt", brCnt[2], 32'd0);
        runBranch(32'h80, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 P1");
        runBranch(32'h40, 1'b0, 1'b0, 2, 1'b1, 1'b1, "m2 A1 local");     // chooser 01->10
        runBranch(32'hC0, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 Q1");
        runBranch(32'h40, 1'b0, 1'b0, 2, 1'b0, 1'b0, "m2 A2 gshare");    // chooser 10->11
        runBranch(32'h40, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 A3 agree");     // chooser held
        runBranch(32'hC0, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 Q2");
        runBranch(32'h40, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 A4 gshare");    // chooser 11->10
        runBranch(32'hC0, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 Q3");
        runBranch(32'h40, 1'b1, 1'b0, 2, 1'b0, 1'b1, "m2 A5 gshare");    // still global
        checkVal("m2 br_cnt", brCnt[2], 32'd9);
        checkVal("m2 mis_cnt", misCnt[2], 32'd8);

        // Async reset with a mispredicting branch in M and a taken prediction in D.
        @(negedge clk);
        pcF = 32'h40; branchD = 1'b0; branchM = 1'b0;
        @(negedge clk);
        branchD = 1'b1;
        @(negedge clk);
        branchD = 1'b0; pcF = 32'h80;
        @(negedge clk);
        branchD = 1'b1; branchM = 1'b1; actual_takeM = 1'b1;
        #1;
        checkVal("prerst mispred m2", mispred[2], 1'b1);
        checkVal("prerst predD m0", predTake[0], 1'b1);
        rst = 1'b1;
        #1;
        checkVal("rst mispred m2", mispred[2], 1'b0);
        checkVal("rst predD m0", predTake[0], 1'b0);
        checkVal("rst br_cnt m2", brCnt[2], 32'd0);
        checkVal("rst mis_cnt m2", misCnt[2], 32'd0);
        @(negedge clk);
        rst = 1'b0; branchD = 1'b0; branchM = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            checkVal($sformatf("postrst br_cnt m%0d", m), brCnt[m], 32'd0);
            checkVal($sformatf("postrst mis_cnt m%0d", m), misCnt[m], 32'd0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
